rv32_mem_arbiter: RTL

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

---
 rtl/rv32_arb_pkg.sv | 19 +
 rtl/rv32_arb_pick.sv | 30 +++
 rtl/rv32_mem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rv32_arb_pkg.sv
// Shared types and default widths for the two-master memory arbiter.
package rv32_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/rv32_arb_pick.sv
// Combinational requester selector. RV32_ARB_ROUND_ROBIN_EN selects round-robin
// on contention; otherwise data has fixed priority over fetch.
module rv32_arb_pick
    import rv32_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef RV32_ARB_ROUND_ROBIN_EN
    input  owner_e ptr,
`endif
    output logic   valid,
    output owner_e sel
);

    always_comb begin
        valid = i_req | d_req;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            sel = ptr;
        end else if (d_req) begin
            sel = OWN_D;
        end else begin
            sel = OWN_I;
        end
`else
        sel = d_req ? OWN_D : OWN_I;
`endif
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory port, one transaction in flight,
// with response timeout. Define RV32_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module rv32_mem_arbiter
    import rv32_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             pick_valid;
    owner_e           pick_sel;
    logic             expired;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    owner_e ptr_q, ptr_d;

    // Favour whichever requester lost the most recent grant.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_valid && m_gnt) begin
            ptr_d = (pick_sel == OWN_D) ? OWN_I : OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= OWN_D;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    rv32_arb_pick u_pick (
        .i_req (i_req),
        .d_req (d_req),
`ifdef RV32_ARB_ROUND_ROBIN_EN
        .ptr   (ptr_q),
`endif
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_be     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    m_req = 1'b1;
                    if (pick_sel == OWN_D) begin
                        m_we    = d_we;
                        m_be    = d_be;
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                        d_gnt   = m_gnt;
                    end else begin
                        m_be   = '1;
                        m_addr = i_addr;
                        i_gnt  = m_gnt;
                    end
                    if (m_gnt) begin
                        state_d = (pick_sel == OWN_D) ? BUSY_D : BUSY_I;
                        cnt_d   = '0;
                        we_d    = (pick_sel == OWN_D) ? d_we : 1'b0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the expiry cycle wins over the timeout.
                if (m_rvalid || expired) begin
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        i_rvalid = 1'b1;
                        i_err    = ~m_rvalid;
                        i_rdata  = m_rvalid ? m_rdata : '0;
                    end else begin
                        d_rvalid = 1'b1;
                        d_err    = ~m_rvalid;
                        d_rdata  = (m_rvalid && !we_q) ? m_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            m_req    = 1'b0;
            i_gnt    = 1'b0;
            d_gnt    = 1'b0;
            i_rvalid = 1'b0;
            i_err    = 1'b0;
            i_rdata  = '0;
            d_rvalid = 1'b0;
            d_err    = 1'b0;
            d_rdata  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

endmodule
